// File: rtl/mem_access_unit_if.sv
// Bundle of the EX-side, data-memory and write-back signals of the memory-access stage.
// EX: an instruction transfers on a rising edge where ex_valid && ex_ready; ex_ready depends on state only.
// Memory: dmem_req holds with stable addr/we/wdata until the edge where dmem_ack is sampled high.
interface mem_access_unit_if;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [15:0] ex_alu_result;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_ready;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_reg_write;
  logic        err;
  logic        busy_dbg;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_alu_result, ex_store_data,
    input  ex_rd, ex_reg_write, dmem_ack, dmem_rdata,
    output ex_ready, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_data, wb_rd, wb_reg_write, err, busy_dbg
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_alu_result, ex_store_data,
    output ex_rd, ex_reg_write, dmem_ack, dmem_rdata,
    input  ex_ready, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_data, wb_rd, wb_reg_write, err, busy_dbg
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: issues LW/SW to a variable-latency data memory,
// stalls upstream while busy and produces a registered write-back packet.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus_io
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [8:0] TMO_W = 9'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  rd_q, rd_d;
  logic        regw_q, regw_d;
  logic        wb_valid_q, wb_valid_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic        wb_regw_q, wb_regw_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 16'd0;
      wdata_q    <= 16'd0;
      we_q       <= 1'b0;
      rd_q       <= 3'd0;
      regw_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 16'd0;
      wb_rd_q    <= 3'd0;
      wb_regw_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      regw_q     <= regw_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_regw_q  <= wb_regw_d;
      err_q      <= err_d;
    end
  end

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd_d       = rd_q;
    regw_d     = regw_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_regw_d  = wb_regw_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_io.ex_valid) begin
          if (bus_io.ex_mem_read && bus_io.ex_mem_write) begin
            wb_valid_d = 1'b1;
            wb_regw_d  = 1'b0;
            err_d      = 1'b1;
          end else if (bus_io.ex_mem_read || bus_io.ex_mem_write) begin
            addr_d  = bus_io.ex_alu_result;
            wdata_d = bus_io.ex_store_data;
            we_d    = bus_io.ex_mem_write;
            rd_d    = bus_io.ex_rd;
            regw_d  = bus_io.ex_reg_write;
            cnt_d   = 8'd0;
            state_d = BUSY;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus_io.ex_alu_result;
            wb_rd_d    = bus_io.ex_rd;
            wb_regw_d  = bus_io.ex_reg_write;
          end
        end
      end
      BUSY: begin
        // An ack in the cycle the counter would expire still completes normally.
        if (bus_io.dmem_ack) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (we_q) begin
            wb_data_d = wdata_q;
            wb_regw_d = 1'b0;
          end else begin
            wb_data_d = bus_io.dmem_rdata;
            wb_regw_d = regw_q;
          end
        end else begin
          cnt_d = cnt_inc;
          if ({1'b0, cnt_q} + 9'd1 >= TMO_W) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_regw_d  = 1'b0;
            err_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.ex_ready     = (state_q == IDLE);
  assign bus_io.stall        = (state_q == BUSY);
  assign bus_io.dmem_req     = (state_q == BUSY);
  assign bus_io.busy_dbg     = (state_q == BUSY);
  assign bus_io.dmem_we      = we_q;
  assign bus_io.dmem_addr    = addr_q;
  assign bus_io.dmem_wdata   = wdata_q;
  assign bus_io.wb_valid     = wb_valid_q;
  assign bus_io.wb_data      = wb_data_q;
  assign bus_io.wb_rd        = wb_rd_q;
  assign bus_io.wb_reg_write = wb_regw_q;
  assign bus_io.err          = err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage directly downstream of the ALU. It takes the ALU `result` as the data-memory address for LW/SW, and the second register operand as store data. It runs a req/ack handshake with a variable-latency data memory and stalls the pipeline while the access is outstanding. It delivers a registered write-back packet: the load data, or the ALU result passed through for non-memory instructions.

## Interface
- `TIMEOUT`, default 15: number of `dmem_req` cycles without `dmem_ack` after which the access is aborted; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ex_valid` in 1: an instruction from EX is presented this cycle.
- `ex_mem_read` in 1: instruction is LW.
- `ex_mem_write` in 1: instruction is SW.
- `ex_alu_result` in 16: ALU result; used as the word address for LW/SW, or as the write-back value otherwise.
- `ex_store_data` in 16: store data for SW.
- `ex_rd` in 3: destination register index.
- `ex_reg_write` in 1: instruction writes the register file.
- `ex_ready` out 1: stage can accept an instruction this cycle.
- `stall` out 1: freeze the upstream PC/IF/ID/EX registers.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out 16: word address.
- `dmem_wdata` out 16: write data.
- `dmem_ack` in 1: memory completes the request this cycle.
- `dmem_rdata` in 16: read data; valid when `dmem_ack` is high and the access is a read.
- `wb_valid` out 1: write-back packet valid (one-cycle pulse).
- `wb_data` out 16: write-back value.
- `wb_rd` out 3: write-back register index.
- `wb_reg_write` out 1: register file write enable for this packet.
- `err` out 1: one-cycle pulse on an illegal op or a timeout.

## Operation
- FSM states: IDLE and BUSY. `ex_ready = (state==IDLE)` and `stall = (state==BUSY)`; both are decoded from state only, with no combinational path from inputs.
- **IDLE, `ex_valid` high, neither read nor write**: pass-through.
  - Next cycle: `wb_valid`=1, `wb_data`=`ex_alu_result`, `wb_rd`=`ex_rd`, `wb_reg_write`=`ex_reg_write`.
  - State stays IDLE.
- **IDLE, `ex_valid` high, exactly one of read/write**:
  - Capture `ex_alu_result`→`dmem_addr`, `ex_store_data`→`dmem_wdata`, `ex_mem_write`→`dmem_we`, and `ex_rd`/`ex_reg_write`.
  - Clear the timeout counter.
  - Go to BUSY.
- **IDLE, read and write both high**: illegal op.
  - Next cycle: `err`=1, `wb_valid`=1, `wb_reg_write`=0.
  - No memory access; state stays IDLE.
- **BUSY**: `dmem_req`=1. `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable until the request ends.
  - **`dmem_ack` high**: go to IDLE. Next cycle `wb_valid`=1.
    - Read: `wb_data`=`dmem_rdata`, `wb_reg_write`=captured `reg_write`.
    - Write: `wb_reg_write`=0, `wb_data`=`dmem_wdata`.
  - **No ack**: increment the counter. When the counter reaches `TIMEOUT`, abort: go to IDLE, and next cycle `err`=1, `wb_valid`=1, `wb_reg_write`=0.
  - **Ack in the same cycle the counter would expire**: ack wins.
- `dmem_ack` while IDLE is ignored.
- `ex_*` inputs while BUSY are ignored; upstream holds them because `stall` is high.
- `wb_data`, `wb_rd` and `wb_reg_write` hold their last values while `wb_valid` is low.
- `wb_valid` and `err` are registered single-cycle pulses.
- Addresses are 16-bit word addresses with no alignment check. Data is not modified; there is no sign or byte handling.
- The counter is 8 bits and saturates; its compare uses `TIMEOUT`.

## Timing
- Reset values: state IDLE, `ex_ready`=1, `stall`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_reg_write`=0, `err`=0, counter=0.
- Reset asserted mid-BUSY: `dmem_req` drops asynchronously, no write-back packet is produced, and the outstanding request is abandoned.
- Pass-through latency: accept on edge N, `wb_valid` during cycle N+1. Back-to-back pass-through sustains one instruction per cycle.
- Memory op latency:
  - Accept on edge N; `dmem_req` is high from cycle N+1.
  - `dmem_ack` sampled high on edge M (M ≥ N+1).
  - `wb_valid` and `ex_ready` are high in cycle M+1.
  - Minimum accept-to-`wb_valid` latency is 2 cycles.
- A new instruction can be accepted in cycle M+1 while that cycle's `wb_valid` pulse is presented.
- Timeout: with no ack, `dmem_req` stays high for exactly `TIMEOUT` cycles. `err` and `wb_valid` pulse in the following cycle.

## Test plan
- **Reset**: assert `rst` asynchronously mid-cycle → all outputs take their reset values immediately; `ex_ready`=1.
- **ADD pass-through**: `ex_valid`=1, `ex_alu_result`=0x1234, `ex_rd`=3, `ex_reg_write`=1 → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=3, `dmem_req` stays 0. Then present three ops back-to-back → three consecutive `wb_valid` pulses.
- **LW with 3-cycle memory**: addr 0x0010, ack on the 3rd req cycle with `dmem_rdata`=0xBEEF → `stall` high for 3 cycles, `dmem_addr` stable at 0x0010, `wb_data`=0xBEEF, `wb_reg_write`=1, `wb_valid` one cycle after ack.
- **SW with zero-wait memory**: ack in the first req cycle, `dmem_we`=1, `dmem_wdata`=0x00A5 → `wb_valid` 2 cycles after accept with `wb_reg_write`=0. A LW accepted in the very next cycle proceeds normally.
- **Timeout**: `TIMEOUT`=4, LW, ack never arrives → `dmem_req` high exactly 4 cycles, then `err`=1, `wb_valid`=1, `wb_reg_write`=0, state IDLE. A repeated run with ack in the 4th cycle → normal completion and no `err`.
- **Illegal op and reset mid-access**:
  - Read and write both high → `err` pulse, no `dmem_req`.
  - Reset asserted in the 2nd BUSY cycle → `dmem_req` drops, no `wb_valid`.
  - A stray `dmem_ack` while IDLE → no effect.
